// File: rtl/brq_mem_arbiter.sv
// brq_mem_arbiter: shares one single-port SRAM between IF and LSU, LSU first,
// with a starvation bound that forces an IF grant after MaxStarve denials.
module brq_mem_arbiter #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 15,
  parameter int MaxStarve = 4
) (
  input  logic                   brq_clk,
  input  logic                   brq_rst,
  input  logic                   if_req,
  input  logic [AddrWidth-1:0]   if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  output logic [DataWidth-1:0]   if_rdata,
  input  logic                   lsu_req,
  input  logic                   lsu_we,
  input  logic [DataWidth/8-1:0] lsu_be,
  input  logic [AddrWidth-1:0]   lsu_addr,
  input  logic [DataWidth-1:0]   lsu_wdata,
  output logic                   lsu_gnt,
  output logic                   lsu_rvalid,
  output logic [DataWidth-1:0]   lsu_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [DataWidth/8-1:0] mem_be,
  output logic [AddrWidth-1:0]   mem_addr,
  output logic [DataWidth-1:0]   mem_wdata,
  input  logic [DataWidth-1:0]   mem_rdata
);
  typedef enum logic [1:0] {R_IDLE, R_IF, R_LSU_RD, R_LSU_WR} resp_e;
  resp_e state, state_next;
  logic [3:0] starve_cnt;
  logic force_if;
  assign force_if = starve_cnt == 4'(MaxStarve);
  assign lsu_gnt = lsu_req && !(force_if && if_req);
  assign if_gnt = if_req && !lsu_gnt;
  assign mem_en = lsu_gnt || if_gnt;
  assign mem_we = lsu_gnt && lsu_we;
  assign mem_be = lsu_gnt ? lsu_be : (if_gnt ? '1 : '0);
  assign mem_addr = lsu_gnt ? lsu_addr : (if_gnt ? if_addr : '0);
  assign mem_wdata = lsu_gnt ? lsu_wdata : '0;
  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      state <= R_IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_next;
      starve_cnt <= (!if_req || if_gnt) ? '0 : (force_if ? starve_cnt : starve_cnt + 4'd1);
    end
  end
  // the response slot always reflects the access issued in the previous cycle
  always_comb begin
    state_next = R_IDLE;
    if (if_gnt) state_next = R_IF;
    else if (lsu_gnt) state_next = lsu_we ? R_LSU_WR : R_LSU_RD;
  end
  assign if_rvalid = state == R_IF;
  assign if_rdata = if_rvalid ? mem_rdata : '0;
  assign lsu_rvalid = state == R_LSU_RD || state == R_LSU_WR;
  assign lsu_rdata = state == R_LSU_RD ? mem_rdata : '0;
endmodule

// File: tb/tb_brq_mem_arbiter.sv
// tb_brq_mem_arbiter: directed + random stimulus against a reference memory and
// arbitration model; responses are checked by a scoreboard monitor.
module tb_brq_mem_arbiter;
  localparam int MS = 4;
  logic brq_clk = 0, brq_rst = 0;
  logic if_req = 0, lsu_req = 0, lsu_we = 0;
  logic [14:0] if_addr = 0, lsu_addr = 0;
  logic [3:0] lsu_be = 0;
  logic [31:0] lsu_wdata = 0;
  logic if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, lsu_rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  logic [14:0] mem_addr;
  brq_mem_arbiter #(.DataWidth(32), .AddrWidth(15), .MaxStarve(MS)) dut (
    .brq_clk(brq_clk), .brq_rst(brq_rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
  always #5 brq_clk = ~brq_clk;

  typedef struct {logic lsu; logic [31:0] data; int cyc;} exp_t;
  exp_t sb[$];
  logic [31:0] sram [0:32767];
  logic [31:0] ref_mem [0:32767];
  int checks = 0, errors = 0, cyc = 0, waited = 0;
  int if_grants = 0, if_wait_run = 0, if_wait_max = 0;
  logic g_if = 0, g_lsu = 0;

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[8*b+:8] = d[8*b+:8];
    return o;
  endfunction

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  always @(posedge brq_clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) sram[mem_addr] = merge(sram[mem_addr], mem_wdata, mem_be);
      else mem_rdata <= sram[mem_addr];
    end
  end

  // monitor: entries granted in an earlier cycle are due now
  always begin
    @(negedge brq_clk);
    #1;
    if (!brq_rst) begin
      chk("rst_rvalid", {if_rvalid, lsu_rvalid}, 0);
      chk("rst_rdata", {if_rdata, lsu_rdata}, 0);
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("rvalid_route", {if_rvalid, lsu_rvalid}, sb[0].lsu ? 2'b01 : 2'b10);
      chk("rdata", sb[0].lsu ? lsu_rdata : if_rdata, sb[0].data);
      chk("other_rdata", sb[0].lsu ? if_rdata : lsu_rdata, 0);
      void'(sb.pop_front());
    end else begin
      chk("unexpected_rvalid", {if_rvalid, lsu_rvalid}, 0);
      chk("idle_rdata", {if_rdata, lsu_rdata}, 0);
    end
  end

  task automatic step(input bit rst_after = 0);
    logic el, ei;
    @(negedge brq_clk);
    g_if = 0;
    g_lsu = 0;
    if (brq_rst) begin
      el = lsu_req && !(waited >= MS && if_req);
      ei = if_req && !el;
      chk("lsu_gnt", lsu_gnt, el);
      chk("if_gnt", if_gnt, ei);
      chk("mem_en", mem_en, el || ei);
      chk("mem_we", mem_we, el && lsu_we);
      chk("mem_addr", mem_addr, el ? lsu_addr : (ei ? if_addr : 15'd0));
      chk("mem_be", mem_be, el ? lsu_be : (ei ? 4'hf : 4'h0));
      chk("mem_wdata", mem_wdata, el ? lsu_wdata : 32'd0);
      if (ei) sb.push_back('{1'b0, ref_mem[if_addr], cyc});
      if (el && lsu_we) begin
        ref_mem[lsu_addr] = merge(ref_mem[lsu_addr], lsu_wdata, lsu_be);
        sb.push_back('{1'b1, 32'd0, cyc});
      end else if (el) sb.push_back('{1'b1, ref_mem[lsu_addr], cyc});
      waited = (if_req && !ei) ? waited + 1 : 0;
      if (if_gnt) if_grants++;
      if_wait_run = (if_req && !if_gnt) ? if_wait_run + 1 : 0;
      if (if_wait_run > if_wait_max) if_wait_max = if_wait_run;
      g_if = ei;
      g_lsu = el;
      if (rst_after) begin
        #1 brq_rst = 0;
        sb.delete();
        waited = 0;
        if_wait_run = 0;
      end
    end
    @(posedge brq_clk);
    #1;
  endtask

  task automatic set_if(input logic r, input logic [14:0] a);
    if_req = r;
    if_addr = a;
  endtask

  task automatic set_lsu(input logic r, input logic we, input logic [3:0] be,
                         input logic [14:0] a, input logic [31:0] d);
    lsu_req = r;
    lsu_we = we;
    lsu_be = be;
    lsu_addr = a;
    lsu_wdata = d;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 32768; i++) begin
      v = $urandom;
      sram[i] = v;
      ref_mem[i] = v;
    end
    sram[4] = 32'h00500093; ref_mem[4] = 32'h00500093;
    sram[16] = 32'h0; ref_mem[16] = 32'h0;
    sram[32] = 32'h12345678; ref_mem[32] = 32'h12345678;
    // reset with both requesting: grants stay combinational
    set_if(1, 15'h8);
    set_lsu(1, 0, 0, 15'h20, 0);
    @(negedge brq_clk);
    chk("rst_mem_en", mem_en, 1);
    chk("rst_lsu_gnt", lsu_gnt, 1);
    @(posedge brq_clk);
    #1 brq_rst = 1;
    step();
    chk("first_gnt_lsu", g_lsu, 1);
    set_lsu(0, 0, 0, 0, 0);
    step();
    set_if(0, 0);
    step(); step();
    // IF only
    set_if(1, 15'h4);
    repeat (3) step();
    set_if(0, 0);
    step(); step();
    // store then load with partial byte enables
    set_lsu(1, 1, 4'b0011, 15'h10, 32'hDEADBEEF);
    step();
    set_lsu(1, 0, 0, 15'h10, 0);
    step();
    set_lsu(0, 0, 0, 0, 0);
    step(); step();
    // contention: IF granted every MS+1 cycles
    if_grants = 0;
    set_if(1, 15'h8);
    set_lsu(1, 0, 0, 15'h30, 0);
    repeat (20) step();
    chk("contention_if_grants", if_grants, 4);
    chk("contention_if_wait", if_wait_max, MS);
    set_if(0, 0);
    set_lsu(0, 0, 0, 0, 0);
    step(); step();
    // interleaved routing
    set_if(1, 15'hC);
    step();
    set_if(0, 0);
    set_lsu(1, 0, 0, 15'h20, 0);
    step();
    set_lsu(0, 0, 0, 0, 0);
    step(); step();
    // reset while a load response is pending
    set_lsu(1, 0, 0, 15'h20, 0);
    step(1);
    set_lsu(0, 0, 0, 0, 0);
    @(negedge brq_clk);
    chk("midrst_lsu_rvalid", lsu_rvalid, 0);
    @(posedge brq_clk);
    #1 brq_rst = 1;
    step(); step();
    // randomized traffic honouring hold-until-grant
    if_wait_max = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!if_req || g_if) set_if($urandom_range(0, 9) < 6, 15'($urandom_range(0, 63)));
      if (!lsu_req || g_lsu)
        set_lsu($urandom_range(0, 9) < 7, 1'($urandom), 4'($urandom),
                15'($urandom_range(0, 63)), $urandom);
      step();
    end
    chk("random_if_wait_bound", if_wait_max > MS, 0);
    set_if(0, 0);
    set_lsu(0, 0, 0, 0, 0);
    repeat (3) step();
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/brq_mem_arbiter.md
Name: brq_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM (instruction + data) between the core's instruction-fetch (IF) port and load/store (LSU) port.
- Sits between the Buraq RV32IM pipeline and the unified memory inside the core top.
- LSU has fixed priority; a starvation counter guarantees IF forward progress.
- Routes 1-cycle-latency read data back to the requester that issued it.

Parameters:
DataWidth, 32, memory word width in bits
AddrWidth, 15, word-address width
MaxStarve, 4, max consecutive cycles IF may be denied while requesting (1..15)

Ports:
brq_clk  in  1  clock, rising-edge
brq_rst  in  1  asynchronous reset, active-low
if_req  in  1  IF read request; held with if_addr until if_gnt
if_addr  in  AddrWidth  IF word address
if_gnt  out  1  IF request accepted this cycle
if_rvalid  out  1  if_rdata valid
if_rdata  out  DataWidth  fetched instruction word
lsu_req  in  1  LSU request; held with its fields until lsu_gnt
lsu_we  in  1  1 = store, 0 = load
lsu_be  in  DataWidth/8  byte enables for stores
lsu_addr  in  AddrWidth  LSU word address
lsu_wdata  in  DataWidth  store data
lsu_gnt  out  1  LSU request accepted this cycle
lsu_rvalid  out  1  load data valid, or store acknowledge
lsu_rdata  out  DataWidth  load data; 0 on store acknowledge
mem_en  out  1  SRAM access enable
mem_we  out  1  SRAM write enable
mem_be  out  DataWidth/8  SRAM byte enables
mem_addr  out  AddrWidth  SRAM address
mem_wdata  out  DataWidth  SRAM write data
mem_rdata  in  DataWidth  SRAM read data, valid the cycle after a read with mem_en

Behaviour:
- Reset (brq_rst=0, async): starve_cnt=0, resp state=R_IDLE; if_rvalid, lsu_rvalid=0; if_rdata, lsu_rdata=0.
- Grant logic is combinational, same cycle as the request. At most one grant per cycle.
  - force_if = (starve_cnt == MaxStarve).
  - If lsu_req && !(force_if && if_req): lsu_gnt=1.
  - Else if if_req: if_gnt=1.
- mem_* drive the granted request's fields combinationally:
  - mem_en = any grant.
  - mem_we = lsu_gnt & lsu_we; IF grants force mem_we=0 and mem_be all ones.
  - With no grant: mem_en=0, all other mem_* = 0.
- starve_cnt:
  - Increments (saturating at MaxStarve) when if_req=1 and if_gnt=0.
  - Clears when if_gnt=1 or if_req=0.
- Response FSM, registered, states R_IDLE, R_IF, R_LSU_RD, R_LSU_WR:
  - Next state = R_IF on if_gnt; R_LSU_RD on lsu_gnt with !lsu_we; R_LSU_WR on lsu_gnt with lsu_we; otherwise R_IDLE.
  - Transitions every cycle, so back-to-back grants pipeline at 1 access/cycle with no bubble.
- Outputs are combinational from state:
  - R_IF: if_rvalid=1, if_rdata=mem_rdata.
  - R_LSU_RD: lsu_rvalid=1, lsu_rdata=mem_rdata.
  - R_LSU_WR: lsu_rvalid=1, lsu_rdata=0.
  - Non-selected rdata outputs = 0.
- Latency: grant at cycle N -> rvalid at cycle N+1. Exactly one rvalid per grant, never dropped.
- Requesters may drop a request only after a grant; the arbiter does not check this.
- Reset mid-operation: any pending response is discarded and no rvalid follows. The first grant after reset release is the next cycle with a request.
- Addresses wrap naturally at 2^AddrWidth; no range checking.

Test Plan:
- Reset: brq_rst=0 with if_req=lsu_req=1 -> all rvalid=0, rdata=0; mem_en follows the combinational grant. Release -> lsu_gnt=1 on the first edge.
- IF only: if_req=1, if_addr=0x0004 for 3 cycles, SRAM preloaded with 0x00500093 at 4 -> if_gnt=1 each cycle; if_rvalid=1 with if_rdata=0x00500093 cycles 2-4; mem_we=0.
- Store then load: LSU store addr 0x0010, wdata 0xDEADBEEF, be=4'b0011 (word previously 0x0), then load 0x0010 -> store ack with lsu_rdata=0; load returns 0x0000BEEF one cycle after its grant.
- Contention: lsu_req and if_req held high continuously, MaxStarve=4 -> LSU granted 4 cycles, IF on the 5th, then repeat. IF never waits more than 4 cycles.
- Interleaved routing: IF grant at cycle N, LSU load grant at N+1 (addr 0x20 = 0x12345678) -> if_rvalid only at N+1, lsu_rvalid with 0x12345678 only at N+2; no cross-routing.
- Mid-op reset: LSU load granted at cycle N, brq_rst asserted before edge N+1 -> lsu_rvalid stays 0; after release, state is R_IDLE.
